// File: rtl/pseudo_rand_pkg.sv
// Shared definitions for the multi-channel pseudo-random source.
//   lfsr_width() : register width chosen for a given output width
//   lfsr_poly()  : low byte of the Galois feedback polynomial per register width
//   DEFAULT_SEED : power-up / fallback seed, truncated by users to their width
//   ROT          : per-channel seed rotation step
//   state_t      : controller states
package pseudo_rand_pkg;

  localparam int ROT = 31;

  localparam logic [256:0] DEFAULT_SEED =
    257'h0_7163e168_713d5431_6684e132_5cd84848_f3048b46_76874654_0c45f864_04e4684a;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic int lfsr_width(input int width);
    if (width <= 64) begin
      return 64;
    end
    if (width <= 128) begin
      return 128;
    end
    return 257;
  endfunction

  function automatic logic [7:0] lfsr_poly(input int lw);
    case (lw)
      64:      return 8'h1B;
      128:     return 8'h87;
      default: return 8'hC5;
    endcase
  endfunction

endpackage

// File: rtl/pseudo_rand_lfsr.sv
// One Galois LFSR channel.
//   clk, reset : clock and synchronous active-high reset (loads rotated default seed)
//   load       : capture rotl(seed, SHIFT)
//   step       : advance one Galois step (lower priority than load)
//   seed       : base seed shared by all channels
//   q          : current register contents
module pseudo_rand_lfsr
  import pseudo_rand_pkg::*;
#(
  parameter int LFSR_WIDTH = 64,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic [LFSR_WIDTH-1:0] q
);

  localparam logic [LFSR_WIDTH-1:0] POLY =
    {{(LFSR_WIDTH-8){1'b0}}, lfsr_poly(LFSR_WIDTH)};
  localparam logic [LFSR_WIDTH-1:0] DEF_SEED = DEFAULT_SEED[LFSR_WIDTH-1:0];

  // Rotating a nonzero seed keeps it nonzero, so every channel stays out of
  // the LFSR lock-up state while the channels start at distinct phases.
  function automatic logic [LFSR_WIDTH-1:0] rotl(input logic [LFSR_WIDTH-1:0] v);
    if (SHIFT == 0) begin
      return v;
    end
    return (v << SHIFT) | (v >> (LFSR_WIDTH - SHIFT));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= rotl(DEF_SEED);
    end else if (load) begin
      q <= rotl(seed);
    end else if (step) begin
      q <= {q[LFSR_WIDTH-2:0], 1'b0} ^ ({LFSR_WIDTH{q[LFSR_WIDTH-1]}} & POLY);
    end
  end

endmodule

// File: rtl/pseudo_rand_mc.sv
// Multi-channel pseudo-random source: NUM_CH independent Galois LFSRs that
// advance on request and can be reseeded from a 32-bit word stream.
//   clk, reset      : clock, synchronous active-high reset
//   advance         : step every channel (ignored while loading a seed)
//   seed_valid/ready: seed word handshake; seed_data is MS word first
//   seed_last       : final word, applies the accumulated seed
//   rand_valid      : rand_vect is usable
//   rand_vect       : channel c at [c*WIDTH +: WIDTH]
// Build option: define PSEUDO_RAND_WHITEN_EN to XOR each channel with its
// own 13-bit left rotation, masking the pure-shift relation between steps.
module pseudo_rand_mc
  import pseudo_rand_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    advance,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [31:0]             seed_data,
  input  logic                    seed_last,
  output logic                    rand_valid,
  output logic [NUM_CH*WIDTH-1:0] rand_vect
);

  localparam int LFSR_WIDTH = lfsr_width(WIDTH);
  localparam logic [LFSR_WIDTH-1:0] DEF_SEED = DEFAULT_SEED[LFSR_WIDTH-1:0];

  state_t                state;
  logic [LFSR_WIDTH-1:0] acc;
  logic [LFSR_WIDTH-1:0] acc_next;
  logic [LFSR_WIDTH-1:0] seed_apply;
  logic                  accept;
  logic                  apply;
  logic                  step;

  assign seed_ready = !reset;
  assign rand_valid = !reset && (state == RUN);

  assign accept = seed_valid && seed_ready;
  assign apply  = accept && seed_last;
  // A seed word wins over advance; LOAD freezes the registers.
  assign step   = advance && (state == RUN) && !accept;

  // Older words fall off the top once more than a register's worth arrives.
  assign acc_next   = {acc[LFSR_WIDTH-33:0], seed_data};
  assign seed_apply = (acc_next == '0) ? DEF_SEED : acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      acc   <= '0;
    end else if (accept) begin
      if (seed_last) begin
        state <= RUN;
        acc   <= '0;
      end else begin
        state <= LOAD;
        acc   <= acc_next;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LFSR_WIDTH-1:0] q;

    pseudo_rand_lfsr #(
      .LFSR_WIDTH(LFSR_WIDTH),
      .SHIFT     ((ROT * c) % LFSR_WIDTH)
    ) u_lfsr (
      .clk  (clk),
      .reset(reset),
      .load (apply),
      .step (step),
      .seed (seed_apply),
      .q    (q)
    );

`ifdef PSEUDO_RAND_WHITEN_EN
    logic [LFSR_WIDTH-1:0] q_rot;
    assign q_rot = {q[LFSR_WIDTH-14:0], q[LFSR_WIDTH-1 -: 13]};
    assign rand_vect[c*WIDTH +: WIDTH] = q[WIDTH-1:0] ^ q_rot[WIDTH-1:0];
`else
    assign rand_vect[c*WIDTH +: WIDTH] = q[WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_pseudo_rand_mc.sv
module tb_pseudo_rand_mc;

  localparam int WIDTH  = 64;
  localparam int NUM_CH = 4;
  localparam logic [63:0] DEF = 64'h0c45f864_04e4684a;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    advance;
  logic                    seed_valid;
  logic                    seed_ready;
  logic [31:0]             seed_data;
  logic                    seed_last;
  logic                    rand_valid;
  logic [NUM_CH*WIDTH-1:0] rand_vect;

  pseudo_rand_mc #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .seed_valid(seed_valid),
    .seed_ready(seed_ready),
    .seed_data (seed_data),
    .seed_last (seed_last),
    .rand_valid(rand_valid),
    .rand_vect (rand_vect)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: one value per channel, a seed accumulator, a loading flag.
  logic [63:0] m_lfsr [NUM_CH];
  logic [63:0] m_acc  = '0;
  bit          m_load = 1'b0;

  function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
    int k;
    k = n % 64;
    if (k == 0) return v;
    return (v << k) | (v >> (64 - k));
  endfunction

  // Multiply by x in GF(2)[x] modulo x^64 + x^4 + x^3 + x + 1.
  function automatic logic [63:0] mul_x(input logic [63:0] v);
    return v[63] ? ((v << 1) ^ 64'h1B) : (v << 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_update();
    logic [63:0] nacc;
    logic [63:0] s;
    if (reset) begin
      m_load = 1'b0;
      m_acc  = '0;
      for (int c = 0; c < NUM_CH; c++) m_lfsr[c] = rotl64(DEF, 31 * c);
    end else if (seed_valid) begin
      nacc = {m_acc[31:0], seed_data};
      if (seed_last) begin
        s = (nacc == 64'd0) ? DEF : nacc;
        for (int c = 0; c < NUM_CH; c++) m_lfsr[c] = rotl64(s, 31 * c);
        m_acc  = '0;
        m_load = 1'b0;
      end else begin
        m_acc  = nacc;
        m_load = 1'b1;
      end
    end else if (advance && !m_load) begin
      for (int c = 0; c < NUM_CH; c++) m_lfsr[c] = mul_x(m_lfsr[c]);
    end
  endtask

  task automatic check_outputs();
    chk("rand_valid", {63'd0, rand_valid}, {63'd0, (!reset && !m_load)});
    chk("seed_ready", {63'd0, seed_ready}, {63'd0, !reset});
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++)
        chk($sformatf("ch%0d", c), rand_vect[c*WIDTH +: WIDTH], m_lfsr[c]);
    end
  endtask

  // Apply inputs just after a falling edge, check, then advance the model.
  task automatic cyc(input logic r, input logic a, input logic sv,
                     input logic [31:0] sd, input logic sl);
    reset      = r;
    advance    = a;
    seed_valid = sv;
    seed_data  = sd;
    seed_last  = sl;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    // Reset and default seeds
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h1234, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_reset_ch0", rand_vect[63:0], 64'h0c45f864_04e4684a);
    chk("lit_reset_ch1", rand_vect[127:64], 64'h02723425_0622fc32);
    chk("lit_valid_after_reset", {63'd0, rand_valid}, 64'd1);

    // Single-word seed, walk the bit to the top, then feedback
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b1);
    chk("lit_seed1_ch0", rand_vect[63:0], 64'h1);
    repeat (63) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("lit_walk_ch0", rand_vect[63:0], 64'h8000_0000_0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("lit_feedback_ch0", rand_vect[63:0], 64'h1B);

    // Two-word seed
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("lit_load_valid", {63'd0, rand_valid}, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h01234567, 1'b1);
    chk("lit_two_word_ch0", rand_vect[63:0], 64'hDEADBEEF_01234567);
    chk("lit_two_word_ch1", rand_vect[127:64], 64'h8091A2B3_EF56DF77);
    chk("lit_two_word_valid", {63'd0, rand_valid}, 64'd1);

    // Zero seed falls back to defaults
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("lit_zero_ch0", rand_vect[63:0], 64'h0c45f864_04e4684a);
    chk("lit_zero_ch1", rand_vect[127:64], 64'h02723425_0622fc32);

    // advance held through a load
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h3, 1'b1);
    chk("lit_adv_load_ch0", rand_vect[63:0], 64'h3);

    // Reset in the middle of a load
    cyc(1'b0, 1'b0, 1'b1, 32'hAAAA5555, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_reset_load_ch0", rand_vect[63:0], 64'h0c45f864_04e4684a);
    cyc(1'b0, 1'b0, 1'b1, 32'h5, 1'b1);
    chk("lit_acc_cleared_ch0", rand_vect[63:0], 64'h5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        a;
      logic        sv;
      logic        sl;
      logic [31:0] sd;
      r  = ($urandom_range(0, 199) == 0);
      a  = $urandom_range(0, 1) == 1;
      sv = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 2) == 0);
      sd = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      cyc(r, a, sv, sd, sl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
